image_row_writer: RTL and testbench
===================================

IMAGE_ROW_WRITER -- requirements
Module: image_row_writer

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 Parameter IMG_W, 64: pixels per row, which is also the memory data width per channel.
REQ-003 Parameter IMG_H, 64: rows per frame.
REQ-004 Parameter ADDR_W, 6: row address width, equal to clog2(IMG_H).
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  sync reset, active-high.
- start  in  1  begin frame load; single-cycle pulse.
- abort  in  1  cancel the load in progress.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  block can accept a pixel.
- pix_rgb  in  3  {r,g,b}, one bit per channel.
- wr_en  out  1  write strobe to the three channel RAMs.
- wr_addr  out  ADDR_W  row address.
- red_wr_data  out  IMG_W  red row.
- green_wr_data  out  IMG_W  green row.
- blue_wr_data  out  IMG_W  blue row.
- busy  out  1  load in progress.
- frame_done  out  1  one-cycle pulse after the last row is written.

Function
REQ-006 The FSM SHALL have four states: IDLE, PACK, WRITE, DONE.
REQ-007 In IDLE, start=1 SHALL clear row and col to 0 and enter PACK on the next cycle; start SHALL be ignored in all other states.
REQ-008 In PACK, pix_ready SHALL be 1; a pixel is accepted only on a cycle where pix_valid and pix_ready are both 1.
REQ-009 An accepted pixel in column c SHALL be stored at bit IMG_W-1-c of each channel row, so pixel 0 is the MSB (display order).
REQ-010 Each acceptance SHALL increment col; the acceptance with col==IMG_W-1 SHALL enter WRITE.
REQ-011 In WRITE, pix_ready SHALL be 0 and wr_en SHALL be 1 for exactly one cycle, with wr_addr=row and the three packed rows on the data ports.
REQ-012 Data SHALL therefore appear one cycle after the 64th pixel is accepted; row throughput is at least IMG_W+1 cycles.
REQ-013 After WRITE: if row==IMG_H-1, enter DONE; otherwise increment row, clear col, and return to PACK.
REQ-014 DONE SHALL last one cycle with frame_done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in PACK, WRITE and DONE, and 0 in IDLE.
REQ-016 wr_data ports SHALL hold their last written value whenever wr_en=0; wr_addr SHALL equal row at all times.
REQ-017 When pix_valid=0 in PACK, the block SHALL hold state, col and row data without change.
REQ-018 abort=1 in PACK or WRITE SHALL go to IDLE on the next cycle; no write SHALL occur on or after that cycle, and the partial row SHALL be discarded.
REQ-019 abort SHALL take priority over the WRITE strobe on the same cycle; abort in IDLE or DONE SHALL have no effect.
REQ-020 col and row counters SHALL be exactly clog2 width and SHALL never wrap in normal use; the terminal compare SHALL decide each transition.

Reset
REQ-021 rst=1 SHALL force, on the next clk edge:
- state IDLE
- row and col 0
- pix_ready, wr_en, busy, frame_done all 0
- wr_addr 0, all wr_data 0
REQ-022 rst SHALL take priority over start and abort, including mid-row, and SHALL suppress any pending write.

Structure
REQ-023 Shared package image_pkg SHALL hold:
- IMG_W, IMG_H, ADDR_W defaults
- the state enum {IDLE, PACK, WRITE, DONE}
REQ-024 Sub-module row_packer SHALL be instantiated three times, once per channel, with inputs clk, rst, clr, load, col and bit_in and output row_q [IMG_W-1:0].
REQ-025 The FSM and counters SHALL live in image_row_writer.

Verification
REQ-026 Reset then start, with 4096 pixels where pix_rgb=3'b100 only at even columns -> 64 wr_en pulses with addr 0..63, red_wr_data=64'hAAAA_AAAA_AAAA_AAAA, green and blue 0, then frame_done one cycle after the addr 63 write.
REQ-027 pix_valid toggled randomly at 50% -> the same RAM contents as the back-to-back run; pix_ready is 0 during each WRITE cycle.
REQ-028 abort after 30 pixels of row 5 -> no write to addr 5; busy=0 next cycle; a new start reloads from addr 0.
REQ-029 rst asserted in WRITE of row 10 -> no wr_en on that edge; all outputs are 0 next cycle.
REQ-030 start pulsed repeatedly during PACK -> no effect; row and col continue unchanged.
REQ-031 Single pixel with rgb=3'b111 at col 0 and the rest 0, row 0 -> red, green and blue wr_data each equal 64'h8000_0000_0000_0000 at addr 0.

Source files
------------

// File: rtl/image_pkg.sv
// Shared frame geometry defaults and the row-writer FSM state encoding.
package image_pkg;
  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_e;
endpackage

// File: rtl/row_packer.sv
// One colour channel: shifts accepted pixel bits into a row, column 0 at the MSB.
module row_packer #(
  parameter int IMG_W = 64,
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [COL_W-1:0] col,
  input  logic             bit_in,
  output logic [IMG_W-1:0] row_q
);
  logic [IMG_W-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (clr)
      row_d = '0;
    else if (load)
      row_d[COL_W'(IMG_W-1) - col] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) row_q <= '0;
    else     row_q <= row_d;
  end
endmodule

// File: rtl/image_row_writer.sv
// Packs a 1-bit-per-channel RGB pixel stream into rows and writes each row
// to three channel RAMs, one row per strobe, for a full frame.
module image_row_writer
  import image_pkg::*;
#(
  parameter int IMG_W  = image_pkg::IMG_W,
  parameter int IMG_H  = image_pkg::IMG_H,
  parameter int ADDR_W = image_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [2:0]        pix_rgb,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IMG_W-1:0]  red_wr_data,
  output logic [IMG_W-1:0]  green_wr_data,
  output logic [IMG_W-1:0]  blue_wr_data,
  output logic              busy,
  output logic              frame_done
);
  localparam int COL_W = $clog2(IMG_W);

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            row_q, row_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [2:0][IMG_W-1:0]        hold_q, hold_d;
  logic [2:0][IMG_W-1:0]        rows;
  logic [2:0][IMG_W-1:0]        wr_data;
  logic                         clr, load, wr_req;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    clr     = 1'b0;
    load    = 1'b0;
    wr_req  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        row_d   = '0;
        col_d   = '0;
        clr     = 1'b1;
        state_d = PACK;
      end
      PACK: if (abort) begin
        clr     = 1'b1;
        state_d = IDLE;
      end else if (pix_valid) begin
        load = 1'b1;
        if (col_q == COL_W'(IMG_W-1)) state_d = WRITE;
        else                          col_d   = col_q + 1'b1;
      end
      WRITE: if (abort) begin
        clr     = 1'b1;
        state_d = IDLE;
      end else begin
        wr_req = 1'b1;
        if (row_q == ADDR_W'(IMG_H-1)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          clr     = 1'b1;
          state_d = PACK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset arriving during WRITE must kill the strobe on that same edge.
  assign wr_en   = wr_req & ~rst;
  assign hold_d  = wr_en ? rows : hold_q;
  assign wr_data = wr_en ? rows : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
    end
  end

  // Channel index follows pix_rgb bit order: 2=red, 1=green, 0=blue.
  for (genvar g = 0; g < 3; g++) begin : g_ch
    row_packer #(.IMG_W(IMG_W), .COL_W(COL_W)) u_pk (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .col    (col_q),
      .bit_in (pix_rgb[g]),
      .row_q  (rows[g])
    );
  end

  assign red_wr_data   = wr_data[2];
  assign green_wr_data = wr_data[1];
  assign blue_wr_data  = wr_data[0];
  assign wr_addr       = row_q;
  assign pix_ready     = (state_q == PACK);
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == DONE);
endmodule

// File: tb/tb_image_row_writer.sv
// Directed bench for image_row_writer: full frames, stalls, abort, reset mid-write.
module tb_image_row_writer;
  logic        clk = 1'b0;
  logic        rst, start, abort, pix_valid, pix_ready;
  logic [2:0]  pix_rgb;
  logic        wr_en, busy, frame_done;
  logic [5:0]  wr_addr;
  logic [63:0] red_wr_data, green_wr_data, blue_wr_data;

  image_row_writer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .red_wr_data(red_wr_data), .green_wr_data(green_wr_data), .blue_wr_data(blue_wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  localparam logic [63:0] ALT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // write log sampled mid-cycle
  int          wr_cnt = 0, fd_cnt = 0, rdy_bad = 0, cyc = 0, fd_cyc = 0, wr63_cyc = 0;
  int          wa [0:511];
  logic [63:0] wrr [0:511], wrg [0:511], wrb [0:511];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      wa[wr_cnt]  = int'(wr_addr);
      wrr[wr_cnt] = red_wr_data;
      wrg[wr_cnt] = green_wr_data;
      wrb[wr_cnt] = blue_wr_data;
      if (wr_addr == 6'd63) wr63_cyc = cyc;
      if (pix_ready) rdy_bad++;
      wr_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  function automatic logic [2:0] pat(input int mode, input int col);
    if (mode == 0) return (col % 2 == 0) ? 3'b100 : 3'b000;
    return (col == 0) ? 3'b111 : 3'b000;
  endfunction

  task automatic start_frame();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Ends at the negedge on which the n-th pixel is accepted.
  task automatic feed(input int n, input int mode, input bit rnd);
    int tries;
    bit acc;
    for (int p = 0; p < n; p++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc) begin
        @(posedge clk); #1;
        pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        pix_rgb   = pat(mode, p % 64);
        @(negedge clk);
        acc = pix_valid && pix_ready;
        tries++;
        if (!acc && tries > 500) begin
          chk("feed_timeout", 64'd0, 64'd1);
          return;
        end
      end
    end
  endtask

  task automatic finish_frame(input int base, input int fd_base);
    int t = 0;
    @(posedge clk); #1; pix_valid = 1'b0; start = 1'b0;
    while (fd_cnt == fd_base && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("frame_done_count", 64'(fd_cnt - fd_base), 64'd1);
    chk("frame_done_lat", 64'(fd_cyc - wr63_cyc), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("wr_count", 64'(wr_cnt - base), 64'd64);
    chk("rdy_during_wr", 64'(rdy_bad), 64'd0);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("addr%0d", i), 64'(wa[base+i]), 64'(i));
      chk($sformatf("red%0d", i), wrr[base+i], ALT);
      chk($sformatf("green%0d", i), wrg[base+i], 64'd0);
      chk($sformatf("blue%0d", i), wrb[base+i], 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(pix_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_red"}, red_wr_data, 64'd0);
    chk({tag, "_green"}, green_wr_data, 64'd0);
    chk({tag, "_blue"}, blue_wr_data, 64'd0);
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_rgb = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // back-to-back frame
    base = wr_cnt;
    start_frame();
    feed(4096, 0, 1'b0);
    finish_frame(base, fd_cnt);

    // 50% valid with stray start pulses during the load
    base = wr_cnt;
    start_frame();
    feed(4096, 0, 1'b1);
    finish_frame(base, fd_cnt);

    // abort after 30 pixels of row 5
    base = wr_cnt;
    start_frame();
    feed(5*64 + 30, 0, 1'b0);
    @(posedge clk); #1; pix_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_count", 64'(wr_cnt - base), 64'd5);
    chk("abort_last_addr", 64'(wa[wr_cnt-1]), 64'd4);

    // restart: single white pixel at column 0 of row 0
    base = wr_cnt;
    start_frame();
    feed(64, 1, 1'b0);
    @(posedge clk); #1; pix_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_count", 64'(wr_cnt - base), 64'd1);
    chk("restart_addr", 64'(wa[base]), 64'd0);
    chk("single_red", wrr[base], MSB);
    chk("single_green", wrg[base], MSB);
    chk("single_blue", wrb[base], MSB);
    chk("hold_wr_en", 64'(wr_en), 64'd0);
    chk("hold_red", red_wr_data, MSB);
    chk("hold_addr", 64'(wr_addr), 64'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort2_busy", 64'(busy), 64'd0);

    // reset during the WRITE of row 10
    base = wr_cnt;
    start_frame();
    feed(11*64, 0, 1'b0);
    @(posedge clk); #1; pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_suppress", 64'(wr_en), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_in_write");
    chk("rst_wr_count", 64'(wr_cnt - base), 64'd10);
    chk("rst_last_addr", 64'(wa[wr_cnt-1]), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
